// File: rtl/data_mem_io_if.sv
// Data-memory bus between the single-cycle core and data_mem_io.
// The core drives address/strobes/write data; the memory returns combinational read data.
interface data_mem_io_if;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        write_en;
  logic        read_en;
  logic [15:0] rdata;

  modport master (output addr, output wdata, output write_en, output read_en, input rdata);
  modport slave  (input addr, input wdata, input write_en, input read_en, output rdata);
endinterface

// File: rtl/data_mem_io.sv
// Word-addressed data RAM plus memory-mapped display register and two synchronised switches.
// Optional switch debounce is built only when DMEM_IO_DEBOUNCE_EN is defined.
module data_mem_io #(
  parameter int unsigned DEPTH      = 64,
  parameter logic [15:0] DISP_ADDR  = 16'hFFF0,
  parameter logic [15:0] SW0_ADDR   = 16'hFFF8,
  parameter logic [15:0] SW1_ADDR   = 16'hFFFA,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic          i_clock,
  input  logic          i_reset,
  data_mem_io_if.slave  bus,
  output logic [15:0]   o_io_display,
  input  logic          i_io_sw0,
  input  logic          i_io_sw1
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] RAM_TOP = 16'(DEPTH);

  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("data_mem_io: DEB_CYCLES must be >= 1");
  end

  logic [15:0]   r_mem [DEPTH];
  logic [15:0]   r_display;
  logic          w_ram_hit;
  logic [AW-1:0] w_ram_idx;
  logic [1:0]    w_sw_raw;
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    w_sw_stable;

  assign w_ram_hit    = (bus.addr < RAM_TOP);
  assign w_ram_idx    = bus.addr[AW-1:0];
  assign w_sw_raw     = {i_io_sw1, i_io_sw0};
  assign o_io_display = r_display;

  // RAM has no reset, but a store coinciding with reset assertion is dropped
  always_ff @(posedge i_clock) begin
    if (i_reset && bus.write_en && w_ram_hit) begin
      r_mem[w_ram_idx] <= bus.wdata;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_display <= '0;
    end else if (bus.write_en && (bus.addr == DISP_ADDR)) begin
      r_display <= bus.wdata;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_sw_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef DMEM_IO_DEBOUNCE_EN
  localparam int unsigned   CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] r_deb_cnt [2];
  logic [1:0]    r_stable;

  // A synced level must disagree with the stable value for DEB_CYCLES edges in a row
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_stable  <= '0;
      r_deb_cnt <= '{default: '0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == CNT_LAST) begin
          r_stable[i]  <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_sw_stable = r_stable;
`else
  assign w_sw_stable = r_sync2;
`endif

  always_comb begin
    bus.rdata = '0;
    if (bus.read_en) begin
      if (w_ram_hit) begin
        bus.rdata = r_mem[w_ram_idx];
      end else if (bus.addr == DISP_ADDR) begin
        bus.rdata = r_display;
      end else if (bus.addr == SW0_ADDR) begin
        bus.rdata = {15'b0, w_sw_stable[0]};
      end else if (bus.addr == SW1_ADDR) begin
        bus.rdata = {15'b0, w_sw_stable[1]};
      end
    end
  end

endmodule

// File: tb/tb_data_mem_io.sv
// Scoreboard bench for data_mem_io: stimulus queues expected read data, a negedge monitor checks it.
// Switch latency expectations follow DMEM_IO_DEBOUNCE_EN (DEB_CYCLES left at 4).
module tb_data_mem_io;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sw0 = 1'b0;
  logic        sw1 = 1'b0;
  logic [15:0] disp;

  always #5 clk = ~clk;

  data_mem_io_if bus ();

  data_mem_io dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .bus          (bus),
    .o_io_display (disp),
    .i_io_sw0     (sw0),
    .i_io_sw1     (sw1)
  );

`ifdef DMEM_IO_DEBOUNCE_EN
  localparam int  LAT = 6;
  localparam bit  DEB = 1'b1;
`else
  localparam int  LAT = 2;
  localparam bit  DEB = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_v   = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_v) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_underflow: got empty queue expected an entry");
        end else begin
          e = sb_q.pop_front();
          check(e.name, bus.rdata, e.exp);
        end
      end
    end
  end

  task automatic cyc(input logic we, input logic re, input logic [15:0] a, input logic [15:0] wd,
                     input logic chk, input logic [15:0] exp, input string name);
    exp_t e;
    bus.write_en = we;
    bus.read_en  = re;
    bus.addr     = a;
    bus.wdata    = wd;
    exp_v        = chk;
    if (chk) begin
      e.name = name;
      e.exp  = exp;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    cyc(1'b1, 1'b0, a, d, 1'b0, 16'h0, "");
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
    cyc(1'b0, 1'b1, a, 16'h0, 1'b1, exp, name);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.addr = '0; bus.wdata = '0; bus.write_en = 1'b0; bus.read_en = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    check("display_reset", disp, 16'h0000);
    rd(16'hFFF0, 16'h0000, "rd_disp_reset");
    rd(16'hFFF8, 16'h0000, "rd_sw0_reset");
    rd(16'hFFFA, 16'h0000, "rd_sw1_reset");
    cyc(1'b0, 1'b0, 16'h0005, 16'h0, 1'b1, 16'h0000, "rd_en_low");

    // RAM and boundaries
    wr(16'h0005, 16'hBEEF);
    rd(16'h0005, 16'hBEEF, "ram5_beef");
    wr(16'h0000, 16'h1111);
    rd(16'd64, 16'h0000, "rd_depth_unmapped");
    wr(16'd64, 16'h7777);
    wr(16'd69, 16'h5555);
    rd(16'h0000, 16'h1111, "ram0_after_depth_wr");
    rd(16'h0005, 16'hBEEF, "ram5_no_alias");
    wr(16'd63, 16'h6363);
    rd(16'd63, 16'h6363, "ram_top_word");
    rd(16'hFFF2, 16'h0000, "rd_unmapped_fff2");
    rd(16'hFFEF, 16'h0000, "rd_unmapped_ffef");

    // display register and read-only switch addresses
    wr(16'hFFF0, 16'h1234);
    check("display_1234", disp, 16'h1234);
    rd(16'hFFF0, 16'h1234, "rd_disp_1234");
    wr(16'hFFF8, 16'h0001);
    rd(16'hFFF8, 16'h0000, "sw0_store_ignored");
    wr(16'hFFFA, 16'h0001);
    rd(16'hFFFA, 16'h0000, "sw1_store_ignored");
    rd(16'hFFF0, 16'h1234, "disp_unchanged");

    // simultaneous read and write
    wr(16'h0007, 16'h0011);
    cyc(1'b1, 1'b1, 16'h0007, 16'h00AA, 1'b1, 16'h0011, "rw_same_old");
    rd(16'h0007, 16'h00AA, "rw_same_new");

    // sw0 level change latency
    sw0 = 1'b1;
    for (int k = 0; k <= LAT + 1; k++) begin
      rd(16'hFFF8, 16'(k >= LAT), $sformatf("sw0_lat_k%0d", k));
    end
    wr(16'hFFF8, 16'h0000);
    rd(16'hFFF8, 16'h0001, "sw0_store_ignored_hi");

    // 2-cycle pulse on sw1
    sw1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) sw1 = 1'b0;
      rd(16'hFFFA, 16'((!DEB) && (k == 2 || k == 3)), $sformatf("sw1_pulse_k%0d", k));
    end

    // asynchronous reset mid-cycle
    wr(16'hFFF0, 16'h00FF);
    check("display_00ff", disp, 16'h00FF);
    cyc(1'b0, 1'b1, 16'hFFF8, 16'h0, 1'b0, 16'h0, "");
    check("sw0_before_reset", bus.rdata, 16'h0001);
    begin
      exp_t e;
      e.name = "sw0_during_reset";
      e.exp  = 16'h0000;
      sb_q.push_back(e);
      exp_v = 1'b1;
    end
    #1 rst_n = 1'b0;
    #1;
    check("display_async_clear", disp, 16'h0000);
    check("sw0_async_clear", bus.rdata, 16'h0000);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    exp_v = 1'b0;
    bus.read_en = 1'b0;
    @(posedge clk); #1;
    rd(16'h0005, 16'hBEEF, "ram5_kept_after_reset");
    rd(16'hFFF0, 16'h0000, "rd_disp_after_reset");

    exp_v = 1'b0;
    bus.read_en = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
